// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Multi-cycle data memory for the pipeline MEM stage. Accepts one load/store
// over a valid/ready request channel, waits LATENCY cycles, then returns a
// one-cycle resp_valid pulse with load data (or the echoed store data).
// Only one request is ever in flight; busy tells the CPU to stall MEM.
//
// State table:
//   state | meaning
//   IDLE  | ready for a new request (req_ready high unless in reset)
//   WAIT  | latency countdown for the captured request
//   RESP  | response cycle, resp_valid high for exactly this cycle
//
// Parameters:
//   DEPTH_WORDS - number of 32-bit words, power of 2, >= 2
//   LATENCY     - cycles from acceptance to resp_valid, >= 1
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   req_valid  in   request present on req_*
//   req_ready  out  request can be accepted this cycle
//   req_write  in   1 = store, 0 = load
//   req_addr   in   byte address (wraps modulo DEPTH_WORDS*4)
//   req_wdata  in   store data
//   resp_valid out  one-cycle response pulse
//   resp_rdata out  load data or echoed store data, held between responses
//   resp_err   out  misaligned access, qualified by resp_valid
//   busy       out  request in flight
//
// Optional feature macro: MISALIGN_CHECK_EN
//   defined   - addresses with req_addr[1:0] != 0 respond with resp_err=1,
//               resp_rdata=0 and never write the array
//   undefined - resp_err is tied low and the low address bits are ignored
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          wr_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          resp_valid_q;
    logic [31:0]   resp_rdata_q;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          handshake;
    logic          commit_en;
    logic          c_write;
    logic [31:0]   c_addr;
    logic [31:0]   c_wdata;
    logic [AW-1:0] c_idx;
    logic          c_misalign;
    logic [33-AW:0] unused_addr_bits;

    assign req_ready = (state_q == IDLE) && !reset;
    assign busy      = (state_q != IDLE);
    assign handshake = req_valid && req_ready;

    // With LATENCY==1 the accepting edge is also the commit edge, so the
    // commit must use the live request rather than the (not yet loaded)
    // capture registers.
    always_comb begin
        c_write = wr_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        if (LATENCY == 1) begin
            c_write = req_write;
            c_addr  = req_addr;
            c_wdata = req_wdata;
        end
    end

    assign commit_en = (LATENCY == 1) ? handshake
                                      : ((state_q == WAIT) && (cnt_q == CW'(1)));
    assign c_idx     = c_addr[AW+1:2];

    // Address bits that never select a word.
    assign unused_addr_bits = {c_addr[31:AW+2], c_addr[1:0]};

`ifdef MISALIGN_CHECK_EN
    logic resp_err_q;

    assign c_misalign = (c_addr[1:0] != 2'b00);
    assign resp_err   = resp_err_q;
`else
    assign c_misalign = 1'b0;
    assign resp_err   = 1'b0;
`endif

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
`ifdef MISALIGN_CHECK_EN
            resp_err_q   <= 1'b0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        wr_q    <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= CW'(LATENCY - 1);
                        state_q <= (LATENCY > 1) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (commit_en) begin
                resp_valid_q <= 1'b1;
                if (c_misalign) begin
                    resp_rdata_q <= '0;
                end else if (c_write) begin
                    resp_rdata_q <= c_wdata;
                end else begin
                    resp_rdata_q <= mem_q[c_idx];
                end
`ifdef MISALIGN_CHECK_EN
                resp_err_q <= c_misalign;
`endif
            end
        end
    end

    // Array is not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && commit_en && c_write && !c_misalign) begin
            mem_q[c_idx] <= c_wdata;
        end
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Multi-cycle data-memory responder that answers the pipeline's MEM-stage load/store requests over a valid/ready request channel and a one-cycle response pulse. It replaces the single-cycle data memory with a memory that has configurable access latency. It also drives a busy signal the CPU uses to stall the MEM stage. It holds one outstanding request at a time.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array; must be a power of 2, >= 2
LATENCY, 2, cycles from request acceptance to resp_valid; integer >= 1

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous active-high reset
req_valid  input  1  requester has a request on req_*
req_ready  output  1  responder can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
resp_valid  output  1  one-cycle pulse: response available
resp_rdata  output  32  load data, or echoed store data
resp_err  output  1  misaligned-access error, qualified by resp_valid
busy  output  1  request in flight; CPU stalls MEM stage

Behaviour:
- Decided interface: one clock (clk); reset is synchronous and active-high (reset).
- States:
  - IDLE: ready for a new request.
  - WAIT: latency countdown.
  - RESP: response cycle.
- req_ready = (state==IDLE) && !reset. This is combinational.
- A handshake occurs when req_valid && req_ready at a rising edge.
  - At that edge, latch req_write, req_addr and req_wdata.
  - Load the counter with LATENCY-1.
  - Next state is WAIT if LATENCY>1, otherwise RESP.
- WAIT:
  - The counter decrements each edge.
  - When the counter is 1 at an edge, next state is RESP.
- Commit edge: the edge that enters RESP.
  - Store: the array word is written with the latched wdata, and resp_rdata <= latched wdata.
  - Load: resp_rdata <= array word read at that edge. Read-before-write is irrelevant because only one request is in flight.
- RESP:
  - resp_valid = 1 for exactly one cycle.
  - Next state is IDLE unconditionally. A new request cannot be accepted in RESP.
- Timing:
  - Accept at edge E gives resp_valid high during the cycle after edge E+LATENCY-1.
  - LATENCY=1 means the response appears in the cycle immediately after acceptance.
  - Back-to-back throughput is one request per LATENCY+1 cycles.
- busy = (state != IDLE). It is combinational.
- Address mapping:
  - word index = req_addr[log2(DEPTH_WORDS)+1 : 2].
  - Upper bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - req_addr[1:0] is ignored unless the optional feature is enabled.
- req_valid while req_ready=0 is ignored. The requester holds its request until the handshake.
- resp_rdata holds its last value after resp_valid falls. Only resp_valid qualifies it.
- Reset:
  - state = IDLE, counter = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - Array contents are not cleared.
  - Reset during WAIT drops the pending request. No array write occurs, and no resp_valid follows.
  - Reset asserted on the same edge as a handshake attempt wins: the request is not accepted.

Optional Feature:
MISALIGN_CHECK_EN
- Defined:
  - A request with req_addr[1:0] != 0 is still accepted and takes the same LATENCY.
  - At the commit edge there is no array write, resp_rdata <= 0, and resp_err <= 1.
  - resp_err is cleared on the next response or on reset.
- Undefined:
  - resp_err is constant 0.
  - Low address bits are ignored; address 0x0000_0007 accesses word 1.

Test Plan:
1. reset held 2 cycles, then released: resp_valid=0, resp_rdata=0, busy=0, req_ready=1 in the first cycle after release.
2. LATENCY=2, store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010:
   - Each resp_valid pulses exactly 2 cycles after its handshake edge.
   - The load returns 0xDEADBEEF.
   - busy is high for 2 cycles per request.
3. DEPTH_WORDS=256: store 0x1234_5678 at 0x0000_0404, then load 0x0000_0004. The load returns 0x1234_5678 (wrap-around).
4. req_valid held high continuously with a stream of 3 loads: exactly 3 handshakes in 9 cycles. req_ready is low during WAIT and RESP, and no request is lost or duplicated.
5. Store 0xAAAA_AAAA to 0x20, then issue a store of 0x5555_5555 to 0x20 with reset asserted one cycle after acceptance:
   - No resp_valid is produced.
   - A subsequent load of 0x20 returns 0xAAAA_AAAA.
6. MISALIGN_CHECK_EN defined, store to 0x0000_0022: resp_valid=1 with resp_err=1 and resp_rdata=0, and the word at 0x20 is unchanged. Undefined: same stimulus writes word 0x20 and resp_err=0.
